// File: rtl/dlfloat16_pkg.sv
// Shared DLFloat16 FPU instruction encoding constants, used by both encoder and decoder.
package dlfloat16_pkg;

  localparam logic [6:0] OPC_FP  = 7'b1011011;
  localparam logic [6:0] OPC_FMA = 7'b0011011;
  localparam logic [6:0] OPC_FMS = 7'b0111011;

  localparam logic [4:0] F5_ADD    = 5'b00000;
  localparam logic [4:0] F5_SUB    = 5'b00001;
  localparam logic [4:0] F5_MUL    = 5'b00010;
  localparam logic [4:0] F5_DIV    = 5'b00011;
  localparam logic [4:0] F5_SGNJ   = 5'b00100;
  localparam logic [4:0] F5_MINMAX = 5'b00101;
  localparam logic [4:0] F5_I2F    = 5'b01000;
  localparam logic [4:0] F5_F2I    = 5'b01001;
  localparam logic [4:0] F5_SQRT   = 5'b01011;
  localparam logic [4:0] F5_CMP    = 5'b10100;

  typedef enum logic [3:0] {
    ENA_NONE   = 4'b0000,
    ENA_ADDSUB = 4'b0001,
    ENA_MUL    = 4'b0010,
    ENA_DIV    = 4'b0011,
    ENA_SQRT   = 4'b0100,
    ENA_SGNJ   = 4'b0101,
    ENA_CMP    = 4'b0110,
    ENA_I2F    = 4'b0111,
    ENA_F2I    = 4'b1000,
    ENA_FMA    = 4'b1001
  } ena_e;

  localparam logic [1:0] SEL1_SGNJ  = 2'b01;
  localparam logic [1:0] SEL1_SGNJN = 2'b10;
  localparam logic [1:0] SEL1_SGNJX = 2'b11;

  localparam logic [2:0] SEL2_MIN = 3'b001;
  localparam logic [2:0] SEL2_MAX = 3'b010;
  localparam logic [2:0] SEL2_EQ  = 3'b011;
  localparam logic [2:0] SEL2_LT  = 3'b100;
  localparam logic [2:0] SEL2_LE  = 3'b101;

  // rm-field values that select a variant instead of a rounding mode
  localparam logic [2:0] RMF_SGNJ  = 3'b000;
  localparam logic [2:0] RMF_SGNJN = 3'b001;
  localparam logic [2:0] RMF_SGNJX = 3'b010;
  localparam logic [2:0] RMF_MIN   = 3'b000;
  localparam logic [2:0] RMF_MAX   = 3'b001;
  localparam logic [2:0] RMF_EQ    = 3'b010;
  localparam logic [2:0] RMF_LT    = 3'b001;
  localparam logic [2:0] RMF_LE    = 3'b000;

  localparam logic [2:0] RM_RSV5 = 3'b101;
  localparam logic [2:0] RM_RSV6 = 3'b110;

  typedef struct packed {
    ena_e       ena;
    logic       op;
    logic [1:0] sel1;
    logic [2:0] sel2;
    logic [2:0] rm;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rs3;
  } enc_req_t;

endpackage

// File: rtl/dlfloat16_instr_encoder_if.sv
// Request and instruction-stream handshakes of the DLFloat16 instruction encoder.
interface dlfloat16_instr_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_ena;
  logic        req_op;
  logic [1:0]  req_sel1;
  logic [2:0]  req_sel2;
  logic [2:0]  req_rm;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [4:0]  req_rs3;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;

  modport master (
    output req_valid, req_ena, req_op, req_sel1, req_sel2, req_rm,
           req_rd, req_rs1, req_rs2, req_rs3, instr_ready,
    input  req_ready, instr_valid, instr
  );

  modport slave (
    input  req_valid, req_ena, req_op, req_sel1, req_sel2, req_rm,
           req_rd, req_rs1, req_rs2, req_rs3, instr_ready,
    output req_ready, instr_valid, instr
  );
endinterface

// File: rtl/dlfloat16_enc_fifo.sv
// Synchronous FIFO with occupancy; read data is zero while empty.
module dlfloat16_enc_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata_c,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full_c,
  output logic                     o_empty_c
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full_c  = (r_level == LW'(DEPTH));
  assign o_empty_c = (r_level == '0);
  assign w_push    = i_push & ~o_full_c;
  assign w_pop     = i_pop & ~o_empty_c;

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= i_wdata;
  end

  assign o_rdata_c = o_empty_c ? '0 : r_mem[r_head];
  assign o_level   = r_level;

endmodule

// File: rtl/dlfloat16_instr_encoder.sv
// Encodes decoded DLFloat16 FPU requests into 32-bit custom RISC-V words and
// queues them for the instruction stream; illegal requests are counted and dropped.
module dlfloat16_instr_encoder
  import dlfloat16_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter logic [1:0]  FMT   = 2'b00
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dlfloat16_instr_encoder_if.slave bus,
  output logic                   err_illegal,
  output logic [7:0]             err_count,
  output logic [$clog2(DEPTH):0] level
);

  enc_req_t    w_req;
  logic        w_legal;
  logic        w_rm_ok;
  logic [6:0]  w_opc;
  logic [4:0]  w_top5;
  logic [4:0]  w_rs2f;
  logic [2:0]  w_rmf;
  logic [31:0] w_word;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic        r_err_illegal;
  logic [7:0]  r_err_count;

  assign w_req = '{
    ena:  ena_e'(bus.req_ena),
    op:   bus.req_op,
    sel1: bus.req_sel1,
    sel2: bus.req_sel2,
    rm:   bus.req_rm,
    rd:   bus.req_rd,
    rs1:  bus.req_rs1,
    rs2:  bus.req_rs2,
    rs3:  bus.req_rs3
  };

  assign w_rm_ok = (w_req.rm != RM_RSV5) && (w_req.rm != RM_RSV6);

  // Field selection per op class; w_top5 is fun5 for R-type and rs3 for R4-type
  always_comb begin
    w_legal = 1'b0;
    w_opc   = OPC_FP;
    w_top5  = F5_ADD;
    w_rs2f  = w_req.rs2;
    w_rmf   = w_req.rm;
    case (w_req.ena)
      ENA_ADDSUB: begin
        w_legal = w_rm_ok;
        w_top5  = w_req.op ? F5_SUB : F5_ADD;
      end
      ENA_MUL: begin
        w_legal = w_rm_ok;
        w_top5  = F5_MUL;
      end
      ENA_DIV: begin
        w_legal = w_rm_ok;
        w_top5  = F5_DIV;
      end
      ENA_SQRT: begin
        w_legal = w_rm_ok;
        w_top5  = F5_SQRT;
        w_rs2f  = '0;
      end
      ENA_I2F: begin
        w_legal = w_rm_ok;
        w_top5  = F5_I2F;
        w_rs2f  = '0;
      end
      ENA_F2I: begin
        w_legal = w_rm_ok;
        w_top5  = F5_F2I;
        w_rs2f  = '0;
      end
      ENA_SGNJ: begin
        w_top5 = F5_SGNJ;
        case (w_req.sel1)
          SEL1_SGNJ:  begin w_legal = 1'b1; w_rmf = RMF_SGNJ;  end
          SEL1_SGNJN: begin w_legal = 1'b1; w_rmf = RMF_SGNJN; end
          SEL1_SGNJX: begin w_legal = 1'b1; w_rmf = RMF_SGNJX; end
          default:    w_legal = 1'b0;
        endcase
      end
      ENA_CMP: begin
        case (w_req.sel2)
          SEL2_MIN: begin w_legal = 1'b1; w_top5 = F5_MINMAX; w_rmf = RMF_MIN; end
          SEL2_MAX: begin w_legal = 1'b1; w_top5 = F5_MINMAX; w_rmf = RMF_MAX; end
          SEL2_EQ:  begin w_legal = 1'b1; w_top5 = F5_CMP;    w_rmf = RMF_EQ;  end
          SEL2_LT:  begin w_legal = 1'b1; w_top5 = F5_CMP;    w_rmf = RMF_LT;  end
          SEL2_LE:  begin w_legal = 1'b1; w_top5 = F5_CMP;    w_rmf = RMF_LE;  end
          default:  w_legal = 1'b0;
        endcase
      end
      ENA_FMA: begin
        w_legal = w_rm_ok;
        w_opc   = w_req.op ? OPC_FMS : OPC_FMA;
        w_top5  = w_req.rs3;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_word   = {w_top5, FMT, w_rs2f, w_req.rs1, w_rmf, w_req.rd, w_opc};
  assign w_accept = bus.req_valid & bus.req_ready;
  assign w_push   = w_accept & w_legal;
  assign w_pop    = bus.instr_valid & bus.instr_ready;

  dlfloat16_enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_wdata   (w_word),
    .i_pop     (w_pop),
    .o_rdata_c (bus.instr),
    .o_level   (level),
    .o_full_c  (w_full),
    .o_empty_c (w_empty)
  );

  assign bus.req_ready   = ~w_full;
  assign bus.instr_valid = ~w_empty;

  // Dropped-request pulse and saturating counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_illegal <= 1'b0;
      r_err_count   <= '0;
    end else begin
      r_err_illegal <= w_accept & ~w_legal;
      if (w_accept && !w_legal && (r_err_count != 8'hFF))
        r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_illegal = r_err_illegal;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_dlfloat16_instr_encoder.sv
// Bench for dlfloat16_instr_encoder: vector table plus scoreboard of expected words,
// with hand sequences for back-pressure, full-FIFO and mid-stream reset.
module tb_dlfloat16_instr_encoder;

  typedef struct {
    logic [3:0]  ena;
    logic        op;
    logic [1:0]  sel1;
    logic [2:0]  sel2;
    logic [2:0]  rm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rs3;
    bit          legal;
    logic [31:0] word;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        err_illegal;
  logic [7:0]  err_count;
  logic [2:0]  level;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_errs = 0;
  bit          mon_en = 1'b0;
  vec_t        cur;
  vec_t        vecs[$];
  vec_t        fvecs[$];
  logic [31:0] exp_q[$];
  logic [31:0] mon_tmp;

  dlfloat16_instr_encoder_if bus();

  dlfloat16_instr_encoder #(.DEPTH(4), .FMT(2'b00)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .err_illegal (err_illegal),
    .err_count   (err_count),
    .level       (level)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] ena, input logic op, input logic [1:0] sel1,
                              input logic [2:0] sel2, input logic [2:0] rm, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rs3,
                              input bit legal, input logic [31:0] word);
    vec_t v;
    v.ena = ena; v.op = op; v.sel1 = sel1; v.sel2 = sel2; v.rm = rm;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.rs3 = rs3; v.legal = legal; v.word = word;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    cur = v;
    bus.req_ena = v.ena;  bus.req_op  = v.op;   bus.req_sel1 = v.sel1;
    bus.req_sel2 = v.sel2; bus.req_rm = v.rm;   bus.req_rd   = v.rd;
    bus.req_rs1 = v.rs1;  bus.req_rs2 = v.rs2;  bus.req_rs3  = v.rs3;
    bus.req_valid = 1'b1;
  endtask

  // Holds the request until accepted; returns #1 after the accepting edge
  task automatic send(input vec_t v);
    int  n;
    bit  ok;
    n = 0; ok = 1'b0;
    apply(v);
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = bus.req_ready;
      @(posedge clk); #1;
      n++;
    end
    bus.req_valid = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: req_ready stayed 0, expected an accept within 20 cycles");
    end else if (!v.legal) begin
      exp_errs = (exp_errs == 255) ? 255 : exp_errs + 1;
    end
  endtask

  // Scoreboard: compare head word, retire on pop, enqueue on legal accept
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mon_en) begin
      if (bus.instr_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_word: got %h, expected no valid word", bus.instr);
        end else begin
          check("instr_order", bus.instr, exp_q[0]);
          if (bus.instr_ready) mon_tmp = exp_q.pop_front();
        end
      end else begin
        check("instr_idle_zero", bus.instr, 32'h0);
      end
      if (bus.req_valid && bus.req_ready && cur.legal) exp_q.push_back(cur.word);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    cur = mk(4'd0, 1'b0, 2'd0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_ena = '0; bus.req_op = 1'b0; bus.req_sel1 = '0;
    bus.req_sel2 = '0; bus.req_rm = '0; bus.req_rd = '0; bus.req_rs1 = '0;
    bus.req_rs2 = '0; bus.req_rs3 = '0; bus.instr_ready = 1'b0;

    // legal vectors
    vecs.push_back(mk(4'd1, 1'b0, 2'd0, 3'd0, 3'd0,  5'd1,  5'd2,  5'd3,  5'd0, 1'b1, 32'h003100DB));
    vecs.push_back(mk(4'd1, 1'b1, 2'd0, 3'd0, 3'd0,  5'd1,  5'd2,  5'd3,  5'd0, 1'b1, 32'h083100DB));
    vecs.push_back(mk(4'd9, 1'b0, 2'd0, 3'd0, 3'd1,  5'd4,  5'd5,  5'd6,  5'd7, 1'b1, 32'h3862921B));
    vecs.push_back(mk(4'd9, 1'b1, 2'd0, 3'd0, 3'd1,  5'd4,  5'd5,  5'd6,  5'd7, 1'b1, 32'h3862923B));
    vecs.push_back(mk(4'd6, 1'b0, 2'd0, 3'd3, 3'd0,  5'd1,  5'd2,  5'd3,  5'd0, 1'b1, 32'hA03120DB));
    vecs.push_back(mk(4'd6, 1'b0, 2'd0, 3'd1, 3'd0,  5'd1,  5'd2,  5'd3,  5'd0, 1'b1, 32'h283100DB));
    vecs.push_back(mk(4'd6, 1'b0, 2'd0, 3'd2, 3'd0,  5'd1,  5'd2,  5'd3,  5'd0, 1'b1, 32'h283110DB));
    vecs.push_back(mk(4'd6, 1'b0, 2'd0, 3'd4, 3'd0,  5'd1,  5'd2,  5'd3,  5'd0, 1'b1, 32'hA03110DB));
    vecs.push_back(mk(4'd6, 1'b0, 2'd0, 3'd5, 3'd0,  5'd1,  5'd2,  5'd3,  5'd0, 1'b1, 32'hA03100DB));
    vecs.push_back(mk(4'd5, 1'b0, 2'd1, 3'd0, 3'd0,  5'd1,  5'd2,  5'd3,  5'd0, 1'b1, 32'h203100DB));
    vecs.push_back(mk(4'd5, 1'b0, 2'd2, 3'd0, 3'd0,  5'd1,  5'd2,  5'd3,  5'd0, 1'b1, 32'h203110DB));
    vecs.push_back(mk(4'd5, 1'b0, 2'd3, 3'd0, 3'd5,  5'd5,  5'd6,  5'd7,  5'd0, 1'b1, 32'h207322DB));
    vecs.push_back(mk(4'd2, 1'b0, 2'd0, 3'd0, 3'd7, 5'd31, 5'd31, 5'd31,  5'd0, 1'b1, 32'h11FFFFDB));
    vecs.push_back(mk(4'd3, 1'b0, 2'd0, 3'd0, 3'd4,  5'd3,  5'd4,  5'd5,  5'd0, 1'b1, 32'h185241DB));
    vecs.push_back(mk(4'd4, 1'b0, 2'd0, 3'd0, 3'd2,  5'd2,  5'd3,  5'd9,  5'd0, 1'b1, 32'h5801A15B));
    vecs.push_back(mk(4'd7, 1'b0, 2'd0, 3'd0, 3'd3,  5'd8,  5'd9, 5'd10,  5'd0, 1'b1, 32'h4004B45B));
    vecs.push_back(mk(4'd8, 1'b0, 2'd0, 3'd0, 3'd0,  5'd1,  5'd2, 5'd12,  5'd0, 1'b1, 32'h480100DB));
    // illegal vectors
    vecs.push_back(mk(4'd0,  1'b0, 2'd0, 3'd0, 3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 1'b0, 32'h0));
    vecs.push_back(mk(4'd10, 1'b0, 2'd0, 3'd0, 3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 1'b0, 32'h0));
    vecs.push_back(mk(4'd15, 1'b0, 2'd0, 3'd0, 3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 1'b0, 32'h0));
    vecs.push_back(mk(4'd5,  1'b0, 2'd0, 3'd0, 3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 1'b0, 32'h0));
    vecs.push_back(mk(4'd6,  1'b0, 2'd0, 3'd0, 3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 1'b0, 32'h0));
    vecs.push_back(mk(4'd6,  1'b0, 2'd0, 3'd6, 3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 1'b0, 32'h0));
    vecs.push_back(mk(4'd6,  1'b0, 2'd0, 3'd7, 3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 1'b0, 32'h0));
    vecs.push_back(mk(4'd1,  1'b0, 2'd0, 3'd0, 3'd5, 5'd1, 5'd2, 5'd3, 5'd0, 1'b0, 32'h0));
    vecs.push_back(mk(4'd9,  1'b0, 2'd0, 3'd0, 3'd6, 5'd4, 5'd5, 5'd6, 5'd7, 1'b0, 32'h0));
    vecs.push_back(mk(4'd4,  1'b0, 2'd0, 3'd0, 3'd5, 5'd2, 5'd3, 5'd0, 5'd0, 1'b0, 32'h0));

    for (int k = 0; k < 5; k++)
      fvecs.push_back(mk(4'd1, 1'b0, 2'd0, 3'd0, 3'd0, 5'(k + 1), 5'd2, 5'd3, 5'd0, 1'b1,
                         32'h0031005B | (32'(k + 1) << 7)));

    // reset state
    repeat (2) @(posedge clk); #1;
    check("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_err_count", 32'(err_count), 32'h0);
    check("rst_err_illegal", 32'(err_illegal), 32'h0);
    check("rst_req_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    bus.instr_ready = 1'b1;
    @(posedge clk); #1;

    // table: encoding, one-cycle latency, error pulse and count
    foreach (vecs[i]) begin
      send(vecs[i]);
      check($sformatf("err_pulse[%0d]", i), 32'(err_illegal), 32'(!vecs[i].legal));
      check($sformatf("err_count[%0d]", i), 32'(err_count), 32'(exp_errs));
      if (vecs[i].legal) begin
        check($sformatf("lat_valid[%0d]", i), 32'(bus.instr_valid), 32'h1);
        check($sformatf("lat_word[%0d]", i), bus.instr, vecs[i].word);
      end else begin
        check($sformatf("no_push[%0d]", i), 32'(level), 32'h0);
      end
    end
    @(posedge clk); #1;
    check("pulse_one_cycle", 32'(err_illegal), 32'h0);
    check("drain_level", 32'(level), 32'h0);

    // saturating error counter
    for (int k = 0; k < 260; k++) send(vecs[vecs.size() - 1]);
    check("err_sat", 32'(err_count), 32'd255);

    // back-pressure: fill, blocked push, pop with request pending, refill
    bus.instr_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(fvecs[k]);
    check("full_level", 32'(level), 32'd4);
    check("full_req_ready", 32'(bus.req_ready), 32'h0);
    apply(fvecs[4]);
    @(posedge clk); #1;
    check("full_no_accept", 32'(level), 32'd4);
    bus.instr_ready = 1'b1;
    @(posedge clk); #1;
    bus.instr_ready = 1'b0;
    check("pop_no_accept_level", 32'(level), 32'd3);
    check("pop_req_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("refill_level", 32'(level), 32'd4);
    @(posedge clk); #1;
    check("stall_level", 32'(level), 32'd4);
    bus.instr_ready = 1'b1;
    n = 0;
    while (level != 0 && n < 20) begin @(posedge clk); #1; n++; end
    check("drain_all_level", 32'(level), 32'h0);
    check("drain_all_sb", 32'(exp_q.size()), 32'h0);

    // asynchronous reset mid-stream
    bus.instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(fvecs[k]);
    check("pre_rst_level", 32'(level), 32'd3);
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_instr_valid", 32'(bus.instr_valid), 32'h0);
    check("arst_level", 32'(level), 32'h0);
    check("arst_err_count", 32'(err_count), 32'h0);
    check("arst_instr", bus.instr, 32'h0);
    exp_q.delete();
    exp_errs = 0;
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    bus.instr_ready = 1'b1;
    @(posedge clk); #1;
    send(vecs[0]);
    check("post_rst_word", bus.instr, 32'h003100DB);
    @(posedge clk); #1;
    check("post_rst_level", 32'(level), 32'h0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dlfloat16_instr_encoder.md
Name: dlfloat16_instr_encoder

Overview:
Issue-side counterpart of the DLFloat16 FPU instruction decoder. Accepts decoded operation requests (ena/op/sel1/sel2/rm plus register indices) over a valid/ready handshake and encodes each one into a 32-bit custom RISC-V instruction word. Encoded words are buffered in a small FIFO and presented to the instruction stream over a second valid/ready handshake. Used by the test sequencer and the host-side issue path to drive the FPU.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
FMT, 2'b00, value placed in instr[26:25] for all R-type words

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  encoder can accept a request
req_ena  in  4  op class: 0001 add/sub, 0010 mul, 0011 div, 0100 sqrt, 0101 sgnj, 0110 cmp/minmax, 0111 i2f, 1000 f2i, 1001 fma/fms
req_op  in  1  add/sub and fma/fms select (0 = add/fma, 1 = sub/fms)
req_sel1  in  2  sgnj variant: 01 sgnj, 10 sgnjn, 11 sgnjx
req_sel2  in  3  cmp variant: 001 min, 010 max, 011 eq, 100 lt, 101 le
req_rm  in  3  rounding mode for rm-carrying ops
req_rd, req_rs1, req_rs2, req_rs3  in  5 each  register indices
instr_valid  out  1  encoded word available
instr_ready  in  1  consumer accepts word
instr  out  32  encoded instruction (head of FIFO)
err_illegal  out  1  one-cycle pulse: an illegal request was dropped
err_count  out  8  saturating count of dropped requests
level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst_n low): FIFO empty, level 0, instr_valid 0, instr 32'h0, err_illegal 0, err_count 0. A transfer in progress at reset is discarded.
- req_ready = (level != DEPTH). No full-FIFO pass-through; a pop does not free space for the same cycle's push.
- Accept = req_valid & req_ready. Encoding is combinational on req_*; the word is written to the tail at the accepting edge. Latency: accept at edge N, instr_valid high after edge N (N+1 cycle).
- instr_valid = (level != 0); instr = mem[head] when valid, else 32'h0. Pop = instr_valid & instr_ready. Head and tail pointers wrap modulo DEPTH.
- Simultaneous push and pop: level unchanged, both pointers advance. Push on empty plus pop of nothing is not possible (pop requires valid).
- Held instr/instr_valid are stable while instr_valid & !instr_ready.
- R-type (opcode 7'b1011011): [31:27]=fun5, [26:25]=FMT, [24:20]=rs2, [19:15]=rs1, [14:12]=rm field, [11:7]=rd.
  add 00000, sub 00001, mul 00010, div 00011 (rm=req_rm); sqrt 01011 (rs2 field forced 0, rm=req_rm); i2f 01000, f2i 01001 (rm=req_rm, rs2 field 0).
  sgnj fun5 00100, rm field 000/001/010 for sel1 01/10/11.
  cmp/minmax: min 00101/000, max 00101/001, eq 10100/010, lt 10100/001, le 10100/000.
- R4-type: fma opcode 7'b0011011, fms 7'b0111011 (by req_op); [31:27]=rs3, [26:25]=FMT, rest as R-type, rm=req_rm.
- Illegal: ena 0000 or >1001; ena 0101 with sel1 00; ena 0110 with sel2 000/110/111; rm 101 or 110 on an rm-carrying op. Illegal requests are accepted (handshake completes), not written, err_illegal pulses the cycle after accept, err_count increments, saturating at 255.

Decomposition:
- Package dlfloat16_pkg: opcode constants (OPC_FP, OPC_FMA, OPC_FMS), fun5 constants, ena class enum, sel1/sel2 encodings, rm-field constants. Shared with the decoder.
- One sub-module: dlfloat16_enc_fifo (DEPTH-parameterised synchronous FIFO with level). Encoding logic stays in the top.

Test Plan:
- add rd=1 rs1=2 rs2=3 rm=000, instr_ready=1 -> instr=32'h003100DB one cycle after accept; level returns to 0.
- sub (op=1) same regs -> 32'h083100DB; fma rd=4 rs1=5 rs2=6 rs3=7 rm=001 -> 32'h3862921B.
- cmp sel2=011 rd=1 rs1=2 rs2=3 -> 32'hA03120DB; sgnj sel1=00 -> no push, err_illegal pulse, err_count=1.
- instr_ready=0, push 5 requests -> req_ready low after 4th, level=4; release -> words emerge in order, wrap verified.
- Full FIFO with simultaneous req_valid and pop -> no accept that cycle, level 3 then refill to 4 next cycle.
- rst_n low mid-stream with level=3 -> instr_valid, level, err_count immediately 0, instr=0.
